ifu_mc: RTL and testbench
=========================

Name: ifu_mc

Overview:
- Instruction fetch unit for the multi-cycle CPU. Sits directly upstream of the multi-cycle controller.
- Owns the PC register, the next-PC selection, the instruction register (IR), and a req/ack handshake to instruction memory, which may have variable latency.
- Supplies opcode/func to the controller and raises fetch_busy so the controller holds its IF state until the instruction word has been captured.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- ACK_TIMEOUT, 16, max cycles imem_req may stay high without imem_ack before a fetch error; 0 disables the timeout.
- TO_W, 5, timeout counter width; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_write  in  1  PC write enable from controller.
- ir_write  in  1  fetch request from controller (IF state).
- npc_op  in  2  00 = pc+4, 01 = relative, 10 = absolute, 11 = rs.
- rs_data  in  32  register rs value, used for jr.
- imem_req  out  1  memory request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26].
- func  out  6  ir[5:0].
- pc  out  32  next fetch address.
- pc_inst  out  32  address of the instruction currently in ir.
- pc_plus4  out  32  pc_inst+4, used for the jal link value.
- fetch_busy  out  1  controller must hold IF while this is high.
- fetch_err  out  1  sticky error flag.
- err_code  out  2  01 = misaligned PC, 10 = ack timeout, 00 = none.
- perf_fetches  out  32  see Optional Feature.
- perf_stalls  out  32  see Optional Feature.

Behaviour:
- Reset values:
  - pc = PC_RESET; pc_inst = PC_RESET; ir = 0.
  - imem_req = 0; imem_addr = PC_RESET.
  - fetch_busy = 0; fetch_err = 0; err_code = 00.
  - FSM state = F_IDLE; timeout counter = 0.
  - Reset asserted mid-fetch: imem_req drops immediately (asynchronous) and any pending ack is discarded.
- F_IDLE:
  - If ir_write and pc[1:0] != 0: go to F_ERR, err_code = 01, no request issued.
  - Else if ir_write: go to F_REQ.
  - imem_req = 0.
  - fetch_busy = ir_write (combinational).
- F_REQ:
  - imem_req = 1 and imem_addr = pc, both held stable until ack.
  - On imem_ack, in the same clock edge:
    - ir <= imem_rdata;
    - pc_inst <= pc;
    - pc <= pc+4;
    - return to F_IDLE.
  - fetch_busy = !imem_ack. The controller therefore leaves IF in the ack cycle, and ir is valid in ID.
  - Timeout counter increments each F_REQ cycle without ack. When it reaches ACK_TIMEOUT (ACK_TIMEOUT != 0), go to F_ERR with err_code = 10.
  - Minimum fetch latency: 1 cycle in F_IDLE plus 1 cycle in F_REQ, i.e. ack in the first F_REQ cycle.
- F_ERR:
  - fetch_err = 1, fetch_busy = 1, imem_req = 0.
  - Exit only via reset, so the CPU halts in IF.
- PC update rule:
  - The pc+4 update happens only at fetch completion. A pc_write with npc_op = 00 is ignored, because the controller asserts it together with ir_write.
  - pc_write with npc_op != 00, in F_IDLE and with ir_write low, loads pc at the clock edge:
    - 01: pc + (sign_extend(ir[15:0]) << 2), where pc is already pc_inst+4.
    - 10: {pc[31:28], ir[25:0], 2'b00}.
    - 11: rs_data.
  - pc_write together with ir_write in the same cycle: the fetch takes priority and the branch load is ignored.
  - pc_write during F_REQ or F_ERR is ignored.
- Arithmetic: all PC additions are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- A misaligned target from jr (rs_data[1:0] != 0) is loaded into pc. The error is raised on the next fetch attempt.
- Derived outputs: opcode, func, and pc_plus4 are continuously derived from the registers.

Optional Feature:
- Macro: IFU_PERF_EN.
- With the macro defined:
  - perf_fetches increments on each completed fetch (ack in F_REQ).
  - perf_stalls increments on each cycle fetch_busy is high.
  - Both counters reset to 0 and wrap at 2^32.
- Without the macro: both outputs are tied to 0 and no counter registers are synthesised.

Test Plan:
- Reset then ir_write = 1, ack in the first F_REQ cycle with rdata = 32'h3C01_1234 -> imem_addr = 0x3000, fetch_busy high for 1 cycle, ir = 32'h3C01_1234, opcode = 6'h0F, pc = 0x3004, pc_inst = 0x3000.
- Ack delayed 3 cycles -> imem_req and addr stay stable for 4 cycles, fetch_busy low only in the ack cycle, perf_stalls = 4 (IFU_PERF_EN).
- After fetching beq with imm = 16'hFFFF at 0x3008: pc_write with npc_op = 01 -> pc = 0x3008; npc_op = 10 with imm26 = 26'h0000C03 -> pc = 0x0000300C; npc_op = 11 with rs_data = 0x3100 -> pc = 0x3100.
- jr to rs_data = 0x3102 then ir_write -> no imem_req, fetch_err = 1, err_code = 01, fetch_busy stuck at 1 until reset.
- ACK_TIMEOUT = 16 and ack never arrives -> after 16 F_REQ cycles, imem_req = 0 and err_code = 10; reset then clears all outputs to their reset values.
- Reset asserted mid-F_REQ and ack arriving the next cycle -> ir stays 0, pc = 0x3000, and the FSM stays in F_IDLE.

Source files
------------

// File: rtl/ifu_mc.sv
// Instruction fetch unit for the multi-cycle CPU: PC, next-PC select, IR and imem req/ack handshake.
// Optional fetch/stall performance counters are enabled with `define IFU_PERF_EN.
module ifu_mc #(
  parameter logic [31:0] PC_RESET    = 32'h0000_3000,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        ir_write,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_inst,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic [1:0]  err_code,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_ERR} state_t;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_REL = 2'b01;
  localparam logic [1:0] NPC_ABS = 2'b10;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     npc;
  logic            to_hit;

  // Branch/jump target; relative targets use pc, which already equals pc_inst+4.
  always_comb begin
    npc = pc;
    case (npc_op)
      NPC_REL: npc = pc + {{14{ir[15]}}, ir[15:0], 2'b00};
      NPC_ABS: npc = {pc[31:28], ir[25:0], 2'b00};
      NPC_SEQ: npc = pc;
      default: npc = rs_data;
    endcase
  end

  assign to_hit = (ACK_TIMEOUT != 0) && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= F_IDLE;
      pc       <= PC_RESET;
      pc_inst  <= PC_RESET;
      ir       <= 32'h0;
      to_cnt   <= '0;
      err_code <= 2'b00;
    end else begin
      case (state)
        F_IDLE: begin
          to_cnt <= '0;
          if (ir_write) begin
            if (pc[1:0] != 2'b00) begin
              state    <= F_ERR;
              err_code <= 2'b01;
            end else begin
              state <= F_REQ;
            end
          end else if (pc_write && npc_op != NPC_SEQ) begin
            pc <= npc;
          end
        end
        F_REQ: begin
          if (imem_ack) begin
            ir      <= imem_rdata;
            pc_inst <= pc;
            pc      <= pc + 32'd4;
            state   <= F_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_hit) begin
              state    <= F_ERR;
              err_code <= 2'b10;
            end
          end
        end
        F_ERR: state <= F_ERR;
        default: state <= F_IDLE;
      endcase
    end
  end

  // Request and busy follow the state register so reset drops them immediately.
  always_comb begin
    fetch_busy = 1'b0;
    case (state)
      F_IDLE:  fetch_busy = ir_write;
      F_REQ:   fetch_busy = !imem_ack;
      F_ERR:   fetch_busy = 1'b1;
      default: fetch_busy = 1'b0;
    endcase
  end

  assign imem_req  = (state == F_REQ);
  assign imem_addr = pc;
  assign fetch_err = (state == F_ERR);
  assign opcode    = ir[31:26];
  assign func      = ir[5:0];
  assign pc_plus4  = pc_inst + 32'd4;

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetches <= 32'h0;
      perf_stalls  <= 32'h0;
    end else begin
      if (state == F_REQ && imem_ack) perf_fetches <= perf_fetches + 32'd1;
      if (fetch_busy)                 perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`else
  assign perf_fetches = 32'h0;
  assign perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_mc.sv
// Directed bench for ifu_mc: fetch timing, next-PC modes, wrap, misalign and timeout errors, reset.
module tb_ifu_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b0;
  logic        ir_write = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic [31:0] rs_data = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_inst;
  logic [31:0] pc_plus4;
  logic        fetch_busy;
  logic        fetch_err;
  logic [1:0]  err_code;
  logic [31:0] perf_fetches;
  logic [31:0] perf_stalls;

  int total = 0;
  int bad   = 0;

  ifu_mc dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .ir_write(ir_write),
    .npc_op(npc_op), .rs_data(rs_data), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode),
    .func(func), .pc(pc), .pc_inst(pc_inst), .pc_plus4(pc_plus4),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err), .err_code(err_code),
    .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc_inst", pc_inst, 32'h3000);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_pf", perf_fetches, 32'h0);
    chk("rst_ps", perf_stalls, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
  endtask

  // One fetch with `delay` ack-less F_REQ cycles before the ack cycle.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int delay);
    @(posedge clk); #1 ir_write = 1'b1;
    @(negedge clk);
    chk("busy_idle", 32'(fetch_busy), 32'h1);
    chk("req_idle", 32'(imem_req), 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req_wait", 32'(imem_req), 32'h1);
      chk("addr_wait", imem_addr, addr);
      chk("busy_wait", 32'(fetch_busy), 32'h1);
      @(posedge clk); #1;
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    chk("req_ack", 32'(imem_req), 32'h1);
    chk("addr_ack", imem_addr, addr);
    chk("busy_ack", 32'(fetch_busy), 32'h0);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    ir_write = 1'b0;
  endtask

  task automatic do_jump(input logic [1:0] op, input logic [31:0] rs);
    @(posedge clk); #1;
    pc_write = 1'b1;
    npc_op = op;
    rs_data = rs;
    @(posedge clk); #1;
    pc_write = 1'b0;
    npc_op = 2'b00;
  endtask

  initial begin
    #12 reset = 1'b0;
    @(negedge clk);
    chk_reset_state();

    // Single-cycle-latency fetch of lui
    do_fetch(32'h3000, 32'h3C01_1234, 0);
    chk("t1_ir", ir, 32'h3C01_1234);
    chk("t1_opcode", 32'(opcode), 32'h0F);
    chk("t1_pc", pc, 32'h3004);
    chk("t1_pc_inst", pc_inst, 32'h3000);
    chk("t1_pc_plus4", pc_plus4, 32'h3004);
`ifdef IFU_PERF_EN
    chk("t1_pf", perf_fetches, 32'd1);
    chk("t1_ps", perf_stalls, 32'd1);
`endif

    // Ack delayed three cycles; four busy cycles for this fetch
    do_fetch(32'h3004, 32'h0000_0020, 3);
    chk("t2_func", 32'(func), 32'h20);
    chk("t2_pc", pc, 32'h3008);
`ifdef IFU_PERF_EN
    chk("t2_pf", perf_fetches, 32'd2);
    chk("t2_ps", perf_stalls, 32'd5);
`endif

    // beq with imm -1 at 0x3008 branches back to itself
    do_fetch(32'h3008, 32'h1000_FFFF, 0);
    chk("t3_pc_seq", pc, 32'h300C);
    do_jump(2'b00, 32'h0);
    chk("t3_seq_ignored", pc, 32'h300C);
    do_jump(2'b01, 32'h0);
    chk("t3_rel", pc, 32'h3008);

    // j with imm26 0xC03; jr first so the absolute load moves pc
    do_fetch(32'h3008, 32'h0800_0C03, 0);
    do_jump(2'b11, 32'h3100);
    chk("t4_jr", pc, 32'h3100);
    do_jump(2'b10, 32'h0);
    chk("t4_abs", pc, 32'h300C);

    // Wraparound at the top of the address space
    do_jump(2'b11, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 1);
    chk("t5_pc_wrap", pc, 32'h0);
    chk("t5_pc_inst", pc_inst, 32'hFFFF_FFFC);
    chk("t5_pc_plus4", pc_plus4, 32'h0);

    // Misaligned jr target raises the error on the next fetch attempt
    do_jump(2'b11, 32'h3102);
    chk("t6_pc", pc, 32'h3102);
    @(posedge clk); #1 ir_write = 1'b1;
    @(posedge clk); #1 ir_write = 1'b0;
    chk("t6_req", 32'(imem_req), 32'h0);
    chk("t6_err", 32'(fetch_err), 32'h1);
    chk("t6_code", 32'(err_code), 32'h1);
    repeat (3) @(posedge clk);
    #1 chk("t6_busy_stuck", 32'(fetch_busy), 32'h1);
    pulse_reset();
    chk_reset_state();

    // Ack never arrives: timeout after 16 F_REQ cycles
    @(posedge clk); #1 ir_write = 1'b1;
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1 chk("t7_req_15", 32'(imem_req), 32'h1);
    chk("t7_err_15", 32'(fetch_err), 32'h0);
    @(posedge clk); #1;
    chk("t7_req_16", 32'(imem_req), 32'h0);
    chk("t7_code", 32'(err_code), 32'h2);
    chk("t7_err", 32'(fetch_err), 32'h1);
    chk("t7_busy", 32'(fetch_busy), 32'h1);
    ir_write = 1'b0;
    pulse_reset();
    chk_reset_state();

    // Reset mid-F_REQ, ack arriving the following cycle is discarded
    @(posedge clk); #1 ir_write = 1'b1;
    @(posedge clk); #1;
    chk("t8_req_before", 32'(imem_req), 32'h1);
    reset = 1'b1;
    #1 chk("t8_req_async", 32'(imem_req), 32'h0);
    #1 reset = 1'b0;
    ir_write = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 imem_ack = 1'b0;
    chk("t8_ir", ir, 32'h0);
    chk("t8_pc", pc, 32'h3000);
    chk("t8_req", 32'(imem_req), 32'h0);
    chk("t8_busy_idle", 32'(fetch_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
